// File: rtl/move_queue_feeder_if.sv
// Decoder-to-feeder move write channel: valid/ready handshake carrying packed
// {e1,e0,z,y,x} speeds and signed step counts.
interface move_queue_feeder_if;
    logic         wr_valid;
    logic         wr_ready;
    logic [159:0] wr_speed;
    logic [159:0] wr_num;

    modport master (output wr_valid, output wr_speed, output wr_num, input wr_ready);
    modport slave  (input wr_valid, input wr_speed, input wr_num, output wr_ready);
endinterface

// File: rtl/move_queue_feeder.sv
// Move command FIFO that issues one move at a time to the motion core, skips
// all-zero moves, enforces an idle gap between moves and halts on motion error.
module move_queue_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    move_queue_feeder_if.slave  wr,
    input  logic                flush,
    input  logic                clear_halt,
    input  logic                finish_in,
    input  logic                error_in,
    output logic [159:0]        speed_out,
    output logic [159:0]        num_out,
    output logic                start_driving,
    output logic                halted,
    output logic                busy,
    output logic [AW:0]         count,
    output logic [31:0]         moves_done
);
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GW      = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, HALT} state_t;

    state_t        state, state_next;
    logic [GW-1:0] gap_cnt, gap_cnt_next;

    logic [159:0]  speed_mem [DEPTH];
    logic [159:0]  num_mem   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    logic push, pop, head_zero, move_ok;

    // Handshake and pop both use the registered count, so a pop never races a
    // write into the head slot.
    assign wr.wr_ready = (count < (AW+1)'(DEPTH)) && !flush;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = (state == IDLE) && (count != '0) && !flush;
    assign head_zero   = (num_mem[rd_ptr] == '0);
    assign move_ok     = (state == DRIVE) && finish_in && !error_in;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy is tracked by
    // the pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            speed_mem[wr_ptr] <= wr.wr_speed;
            num_mem[wr_ptr]   <= wr.wr_num;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and a latch cannot be inferred.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        case (state)
            IDLE:  if (pop && !head_zero) state_next = DRIVE;
            DRIVE: begin
                if (finish_in) begin
                    if (error_in) begin
                        state_next = HALT;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = GW'(GAP_EFF - 1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_next = IDLE;
                else               gap_cnt_next = gap_cnt - 1'b1;
            end
            HALT:    if (clear_halt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The issued move stays on the outputs after completion until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_out  <= '0;
            num_out    <= '0;
            moves_done <= '0;
        end else begin
            if (pop) begin
                speed_out <= speed_mem[rd_ptr];
                num_out   <= num_mem[rd_ptr];
            end
            if ((pop && head_zero) || move_ok) moves_done <= moves_done + 32'd1;
        end
    end

    assign start_driving = (state == DRIVE);
    assign halted        = (state == HALT);
    assign busy          = (state != IDLE) || (count != '0);
endmodule
